// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer: nested r/c/i/j/out_chan loop generator with start/done handshake and pipeline drain.
module conv_loop_sequencer #(
  parameter int OUT_SIZE    = 2,
  parameter int K           = 3,
  parameter int OUT_CHANNEL = 1,
  parameter int PIPE_LAT    = 9
) (
  input  logic       clock_i,
  input  logic       resetn_i,
  input  logic       start_i,
  input  logic       stall_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       iter_valid_o,
  output logic [3:0] r_o,
  output logic [3:0] c_o,
  output logic [3:0] i_o,
  output logic [3:0] j_o,
  output logic [1:0] out_chan_o,
  output logic       acc_clear_o,
  output logic       acc_last_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DW = PIPE_LAT > 2 ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT > 0 ? PIPE_LAT - 1 : 0);
  state_t state_q, state_d;
  logic [3:0] r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;
  logic [1:0] oc_q, oc_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic adv, j_w, i_w, c_w, r_w, oc_w, cj, ci, cc, cr, co;
  assign j_w  = j_q == 4'(K - 1);
  assign i_w  = i_q == 4'(K - 1);
  assign c_w  = c_q == 4'(OUT_SIZE - 1);
  assign r_w  = r_q == 4'(OUT_SIZE - 1);
  assign oc_w = oc_q == 2'(OUT_CHANNEL - 1);
  // Carry chain: each index steps only when every inner index wraps.
  assign adv = state_q == RUN && !stall_i;
  assign cj  = adv && j_w;
  assign ci  = cj && i_w;
  assign cc  = ci && c_w;
  assign cr  = cc && r_w;
  assign co  = cr && oc_w;
  always_comb begin
    j_d  = adv ? (j_w ? '0 : j_q + 4'd1) : j_q;
    i_d  = cj ? (i_w ? '0 : i_q + 4'd1) : i_q;
    c_d  = ci ? (c_w ? '0 : c_q + 4'd1) : c_q;
    r_d  = cc ? (r_w ? '0 : r_q + 4'd1) : r_q;
    oc_d = cr ? (oc_w ? '0 : oc_q + 2'd1) : oc_q;
    cnt_d = co ? DRAIN_INIT : (state_q == DRAIN && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    state_d = state_q == IDLE  ? (start_i ? RUN : IDLE) :
              state_q == RUN   ? (co ? (PIPE_LAT == 0 ? DONE : DRAIN) : RUN) :
              state_q == DRAIN ? (cnt_q == '0 ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      oc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
      oc_q    <= oc_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy_o       = state_q == RUN || state_q == DRAIN;
  assign done_o       = state_q == DONE;
  assign iter_valid_o = adv;
  assign r_o          = r_q;
  assign c_o          = c_q;
  assign i_o          = i_q;
  assign j_o          = j_q;
  assign out_chan_o   = oc_q;
  assign acc_clear_o  = adv && i_q == '0 && j_q == '0;
  assign acc_last_o   = adv && i_w && j_w;
endmodule

// File: tb/tb_conv_loop_sequencer.sv
// tb_conv_loop_sequencer: scoreboard bench for a default instance and a K=1, 4-channel instance.
module tb_conv_loop_sequencer;
  logic clk = 0, resetn = 0;
  logic start = 0, stall = 0, start2 = 0, stall2 = 0;
  logic busy, done, vld, clr, lst, busy2, done2, vld2, clr2, lst2;
  logic [3:0] r, c, i, j, r2, c2, i2, j2;
  logic [1:0] oc, oc2;
  int errors = 0, checks = 0;
  logic [19:0] q[$], q2[$];

  always #5 clk = ~clk;

  conv_loop_sequencer dut (
    .clock_i(clk), .resetn_i(resetn), .start_i(start), .stall_i(stall),
    .busy_o(busy), .done_o(done), .iter_valid_o(vld),
    .r_o(r), .c_o(c), .i_o(i), .j_o(j), .out_chan_o(oc),
    .acc_clear_o(clr), .acc_last_o(lst)
  );

  conv_loop_sequencer #(.OUT_SIZE(2), .K(1), .OUT_CHANNEL(4), .PIPE_LAT(9)) dut2 (
    .clock_i(clk), .resetn_i(resetn), .start_i(start2), .stall_i(stall2),
    .busy_o(busy2), .done_o(done2), .iter_valid_o(vld2),
    .r_o(r2), .c_o(c2), .i_o(i2), .j_o(j2), .out_chan_o(oc2),
    .acc_clear_o(clr2), .acc_last_o(lst2)
  );

  function automatic logic [19:0] tap(input int tr, tc, ti, tj, toc, tk);
    return {4'(tr), 4'(tc), 4'(ti), 4'(tj), 2'(toc), 1'(ti == 0 && tj == 0), 1'(ti == tk - 1 && tj == tk - 1)};
  endfunction

  task automatic test_reset();
    resetn = 0;
    #12;
    checks++;
    if ({busy, done, vld, r, c, i, j, oc, clr, lst} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, vld, r, c, i, j, oc, clr, lst});
    end
    @(posedge clk); #1 resetn = 1;
  endtask

  task automatic run_default(input int st_lo, input int st_hi, input bit noisy, input string nm);
    int run_end = 36 + (st_hi >= st_lo ? st_hi - st_lo + 1 : 0);
    int nclr = 0, nlst = 0;
    logic [19:0] e;
    for (int oc_ = 0; oc_ < 1; oc_++)
      for (int r_ = 0; r_ < 2; r_++)
        for (int c_ = 0; c_ < 2; c_++)
          for (int i_ = 0; i_ < 3; i_++)
            for (int j_ = 0; j_ < 3; j_++) q.push_back(tap(r_, c_, i_, j_, oc_, 3));
    start = 1;
    @(posedge clk); #1 start = 0;
    for (int k = 1; k <= run_end + 12; k++) begin
      stall = k >= st_lo && k <= st_hi;
      start = noisy && (k == 10 || k == 40 || k == run_end + 10);
      @(negedge clk);
      checks++;
      if ({busy, done, vld} !== {1'(k <= run_end + 9), 1'(k == run_end + 10), 1'(k <= run_end && !stall)}) begin
        errors++;
        $display("FAIL %s ctl cyc=%0d got busy/done/vld=%b%b%b want=%b%b%b", nm, k, busy, done, vld,
                 k <= run_end + 9, k == run_end + 10, k <= run_end && !stall);
      end
      if (stall) begin
        checks++;
        if ({r, c, i, j} !== 16'h0011) begin
          errors++;
          $display("FAIL %s stall_hold cyc=%0d got=%h want=0011", nm, k, {r, c, i, j});
        end
      end
      if (vld) begin
        nclr += clr;
        nlst += lst;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_tap cyc=%0d got=%h want=none", nm, k, {r, c, i, j, oc, clr, lst});
        end else begin
          e = q.pop_front();
          if ({r, c, i, j, oc, clr, lst} !== e) begin
            errors++;
            $display("FAIL %s tap cyc=%0d got=%h want=%h", nm, k, {r, c, i, j, oc, clr, lst}, e);
          end
        end
      end
      @(posedge clk); #1;
    end
    start = 0;
    stall = 0;
    checks++;
    if (q.size() != 0 || nclr != 4 || nlst != 4) begin
      errors++;
      $display("FAIL %s totals left=%0d clr=%0d lst=%0d want 0/4/4", nm, q.size(), nclr, nlst);
    end
    q.delete();
  endtask

  task automatic test_k1();
    logic [19:0] e;
    for (int o = 0; o < 4; o++)
      for (int r_ = 0; r_ < 2; r_++)
        for (int c_ = 0; c_ < 2; c_++) q2.push_back(tap(r_, c_, 0, 0, o, 1));
    start2 = 1;
    @(posedge clk); #1 start2 = 0;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      checks++;
      if ({busy2, done2, vld2} !== {1'(k <= 25), 1'(k == 26), 1'(k <= 16)}) begin
        errors++;
        $display("FAIL k1 ctl cyc=%0d got=%b%b%b want=%b%b%b", k, busy2, done2, vld2, k <= 25, k == 26, k <= 16);
      end
      if (vld2) begin
        checks++;
        e = q2.size() ? q2.pop_front() : 20'hFFFFF;
        if ({r2, c2, i2, j2, oc2, clr2, lst2} !== e) begin
          errors++;
          $display("FAIL k1 tap cyc=%0d got=%h want=%h", k, {r2, c2, i2, j2, oc2, clr2, lst2}, e);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (q2.size() != 0) begin
      errors++;
      $display("FAIL k1 taps_left got=%0d want=0", q2.size());
    end
  endtask

  task automatic test_start_held();
    logic eb;
    start = 1;
    @(posedge clk); #1;
    for (int k = 1; k <= 95; k++) begin
      @(negedge clk);
      eb = k <= 45 || (k >= 48 && k <= 92) || k >= 95;
      checks++;
      if ({busy, done} !== {eb, 1'(k == 46 || k == 93)}) begin
        errors++;
        $display("FAIL start_held cyc=%0d got busy/done=%b%b want=%b%b", k, busy, done, eb, k == 46 || k == 93);
      end
      @(posedge clk); #1;
    end
    start = 0;
    resetn = 0;
    @(posedge clk); #1 resetn = 1;
  endtask

  task automatic test_reset_midrun();
    int seen = 0;
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (19) @(posedge clk);
    #2 resetn = 0;
    #1;
    checks++;
    if ({busy, done, vld, r, c, i, j, oc, clr, lst} !== 23'd0) begin
      errors++;
      $display("FAIL midrun_reset got=%h want=0", {busy, done, vld, r, c, i, j, oc, clr, lst});
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    repeat (30) begin
      @(negedge clk);
      seen += done;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done got done=%0d busy=%b want 0/0", seen, busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    run_default(0, -1, 0, "basic");
    run_default(5, 7, 0, "stall");
    run_default(0, -1, 1, "noisy_start");
    test_k1();
    test_start_held();
    test_reset_midrun();
    run_default(0, -1, 0, "after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_loop_sequencer.md
Name: conv_loop_sequencer

Overview:
Generates the convolution loop iterators (r, c, i, j) and the output-channel index that drive the conv address controller, which is otherwise fed by hand. A single start/done handshake runs one full layer. The block also produces accumulator framing strobes per output pixel. After the last tap it waits out the address/output pipeline delay before signalling done.

Parameters:
OUT_SIZE, 2, output feature map edge; r and c run 0..OUT_SIZE-1; legal range 1..15
K, 3, weight kernel edge; i and j run 0..K-1; legal range 1..15
OUT_CHANNEL, 1, number of output channels; out_chan runs 0..OUT_CHANNEL-1; legal range 1..4
PIPE_LAT, 9, drain cycles after the last iteration; equals the controller register stage plus the 8-stage output-address delay

Ports:
clock  in  1  single clock; all state updates on the rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request one layer run; sampled only in IDLE
stall  in  1  freeze iteration while in RUN
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse in the DONE state
iter_valid  out  1  r/c/i/j/out_chan hold a tap to be consumed this cycle
r  out  4  output row iterator
c  out  4  output column iterator
i  out  4  kernel row iterator
j  out  4  kernel column iterator
out_chan  out  2  output channel index
acc_clear  out  1  first tap of an output pixel (i==0 and j==0) with iter_valid
acc_last  out  1  last tap of an output pixel (i==K-1 and j==K-1) with iter_valid

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; all outputs 0; drain counter 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when start=1 at an edge, go to RUN. Iterators are already 0.
- RUN: iter_valid = !stall (combinational from state and stall). acc_clear and acc_last are gated by iter_valid.
- RUN advance: on each edge with stall=0, iterators advance in nested order, j innermost, then i, then c, then r, then out_chan outermost. Each index wraps to 0 at its maximum and carries to the next index.
- RUN stall: with stall=1, all iterators hold and the state stays RUN.
- Last iteration: when a non-stalled edge sees j=K-1, i=K-1, c=OUT_SIZE-1, r=OUT_SIZE-1 and out_chan=OUT_CHANNEL-1, all iterators return to 0, the state goes to DRAIN and the drain counter loads PIPE_LAT-1.
- DRAIN: iter_valid=0 and stall is ignored. The counter decrements each cycle; at 0 the state goes to DONE. DRAIN therefore lasts exactly PIPE_LAT cycles. PIPE_LAT=0 goes straight from RUN to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then the state goes to IDLE.
- start outside IDLE is ignored; there is no queuing. start in the DONE cycle is also ignored, so a new run needs start in IDLE.
- Run length without stalls: RUN = OUT_CHANNEL*OUT_SIZE^2*K^2 cycles. With the default parameters that is 36 RUN cycles, 9 DRAIN cycles, then 1 DONE cycle.
- Iterators are registered outputs. Upper bits beyond the parameter range are always 0; for example out_chan stays 0 when OUT_CHANNEL=1.
- K=1: acc_clear and acc_last are both high on every valid tap.
- Reset mid-run: the block returns to IDLE immediately and done is never pulsed.

Test Plan:
- Default params; reset, then start=1 for one cycle at edge 0 -> RUN cycles 1..36 with iter_valid=1. Cycle 1 shows (r,c,i,j)=(0,0,0,0); cycle 2 shows (0,0,0,1); cycle 4 shows (0,0,1,0); cycle 10 shows (0,1,0,0); cycle 36 shows (1,1,2,2). busy=1 on cycles 1..45, done=1 only on cycle 46, IDLE from cycle 47.
- Default params, acc strobes -> acc_clear on cycles 1, 10, 19 and 28; acc_last on cycles 9, 18, 27 and 36; exactly 4 of each.
- stall=1 on cycles 5..7 of a default run -> iterators frozen at (0,0,1,1) and iter_valid=0 on those cycles. The last tap moves to cycle 39 and done to cycle 49.
- OUT_CHANNEL=4, OUT_SIZE=2, K=1 -> 16 valid taps with out_chan stepping 0..3 every 4 taps, acc_clear=acc_last=1 on every tap, one done pulse.
- start held high continuously -> a new run begins only after the IDLE return, i.e. one done per 47-cycle period. start pulses during RUN, DRAIN or DONE have no effect.
- resetn=0 at cycle 20 of a run -> outputs 0 and state IDLE asynchronously, no done pulse. After release, start gives a clean run from (0,0,0,0).
